// File: rtl/uart_8250_ctrl.sv
// uart_8250_ctrl: Wishbone master that initialises a uart_8250 and moves bytes through THR/RBR; optional ACK timeout via UART_CTRL_TIMEOUT_EN.
// Latency: registered bus outputs with one idle cycle between accesses; rx_valid pulses one cycle after the RBR ACK.
// Backpressure: tx_ready low while a byte is held; LSR polled before every THR write and RBR read; ACK wait unbounded unless the macro is set.
module uart_8250_ctrl #(
  parameter logic [31:0] BASE_ADDR      = 32'h1250_0000,
  parameter int          REG_SHIFT      = 2,
  parameter logic [15:0] DIVISOR        = 16'd27,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  input  logic [31:0] DAT_I,
  output logic        WE_O,
  output logic [3:0]  SEL_O,
  output logic        STB_O,
  input  logic        ACK_I,
  output logic        CYC_O,
  input  logic        INT_I,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        init_done,
  output logic        bus_err
);

  localparam logic [2:0] IDX_RBR = 3'd0;
  localparam logic [2:0] IDX_IER = 3'd1;
  localparam logic [2:0] IDX_FCR = 3'd2;
  localparam logic [2:0] IDX_LCR = 3'd3;
  localparam logic [2:0] IDX_LSR = 3'd5;

  typedef enum logic [3:0] {
    S_INIT0, S_INIT1, S_INIT2, S_INIT3, S_INIT4, S_INIT5,
    S_IDLE, S_RX_LSR, S_RX_RBR, S_TX_LSR, S_TX_THR
  } state_t;

  state_t      state, nxt_state;
  logic        hold_full;
  logic [7:0]  hold_dat;
  logic        acc_req, acc_we;
  logic [2:0]  acc_idx;
  logic [7:0]  acc_dat;
  logic        bus_done;
  logic        timeout_hit;
  logic        unused_bits;

  function automatic logic [31:0] reg_addr(input logic [2:0] idx);
    return BASE_ADDR + (32'(idx) << REG_SHIFT);
  endfunction

  assign bus_done    = STB_O && ACK_I;
  assign tx_ready    = init_done && !hold_full;
  assign unused_bits = ^{DAT_I[31:8], 16'(TIMEOUT_CYCLES)};

`ifdef UART_CTRL_TIMEOUT_EN
  logic [15:0] to_cnt;

  assign timeout_hit = STB_O && !ACK_I && (to_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK_I) begin
    if (RST_I || !STB_O || ACK_I || timeout_hit) to_cnt <= '0;
    else                                          to_cnt <= to_cnt + 16'd1;
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I)            bus_err <= 1'b0;
    else if (timeout_hit) bus_err <= 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
  assign bus_err     = 1'b0;
`endif

  always_ff @(posedge CLK_I) begin
    if (RST_I) state <= S_INIT0;
    else       state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      S_INIT0:  if (bus_done) nxt_state = S_INIT1;
      S_INIT1:  if (bus_done) nxt_state = S_INIT2;
      S_INIT2:  if (bus_done) nxt_state = S_INIT3;
      S_INIT3:  if (bus_done) nxt_state = S_INIT4;
      S_INIT4:  if (bus_done) nxt_state = S_INIT5;
      S_INIT5:  if (bus_done) nxt_state = S_IDLE;
      // RX first so a draining FIFO is never starved by a stalled transmitter
      S_IDLE: begin
        if (INT_I)          nxt_state = S_RX_LSR;
        else if (hold_full) nxt_state = S_TX_LSR;
      end
      S_RX_LSR: if (bus_done) nxt_state = DAT_I[0] ? S_RX_RBR : S_IDLE;
      S_RX_RBR: if (bus_done) nxt_state = S_IDLE;
      S_TX_LSR: if (bus_done) nxt_state = DAT_I[5] ? S_TX_THR : S_IDLE;
      S_TX_THR: if (bus_done) nxt_state = S_IDLE;
      default:  nxt_state = S_INIT0;
    endcase
    if (timeout_hit) nxt_state = init_done ? S_IDLE : S_INIT0;
  end

  always_comb begin
    acc_req = 1'b1;
    acc_we  = 1'b0;
    acc_idx = IDX_RBR;
    acc_dat = 8'h00;
    case (state)
      S_INIT0:  begin acc_we = 1'b1; acc_idx = IDX_LCR; acc_dat = 8'h83;          end
      S_INIT1:  begin acc_we = 1'b1; acc_idx = IDX_RBR; acc_dat = DIVISOR[7:0];  end
      S_INIT2:  begin acc_we = 1'b1; acc_idx = IDX_IER; acc_dat = DIVISOR[15:8]; end
      S_INIT3:  begin acc_we = 1'b1; acc_idx = IDX_LCR; acc_dat = 8'h03;          end
      S_INIT4:  begin acc_we = 1'b1; acc_idx = IDX_FCR; acc_dat = 8'h07;          end
      S_INIT5:  begin acc_we = 1'b1; acc_idx = IDX_IER; acc_dat = 8'h01;          end
      S_RX_LSR: acc_idx = IDX_LSR;
      S_RX_RBR: acc_idx = IDX_RBR;
      S_TX_LSR: acc_idx = IDX_LSR;
      S_TX_THR: begin acc_we = 1'b1; acc_idx = IDX_RBR; acc_dat = hold_dat;       end
      default:  acc_req = 1'b0;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      CYC_O     <= 1'b0;
      STB_O     <= 1'b0;
      WE_O      <= 1'b0;
      ADR_O     <= '0;
      DAT_O     <= '0;
      SEL_O     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      init_done <= 1'b0;
      hold_full <= 1'b0;
      hold_dat  <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (tx_valid && tx_ready) begin
        hold_dat  <= tx_data;
        hold_full <= 1'b1;
      end
      if (STB_O) begin
        if (ACK_I || timeout_hit) begin
          CYC_O <= 1'b0;
          STB_O <= 1'b0;
          WE_O  <= 1'b0;
          ADR_O <= '0;
          DAT_O <= '0;
          SEL_O <= '0;
        end
        // an aborted access leaves the held byte and rx outputs untouched
        if (ACK_I) begin
          case (state)
            S_RX_RBR: begin rx_data <= DAT_I[7:0]; rx_valid <= 1'b1; end
            S_TX_THR: begin hold_full <= 1'b0; hold_dat <= '0; end
            S_INIT5:  init_done <= 1'b1;
            default:  ;
          endcase
        end
      end else if (acc_req) begin
        CYC_O <= 1'b1;
        STB_O <= 1'b1;
        WE_O  <= acc_we;
        ADR_O <= reg_addr(acc_idx);
        DAT_O <= {24'h0, acc_dat};
        SEL_O <= 4'b0001;
      end
    end
  end

endmodule

// File: tb/tb_uart_8250_ctrl.sv
// Bench for uart_8250_ctrl: behavioural UART slave (rx FIFO, THRE busy count, spurious IRQ) plus
// an expected-access queue and expected-byte queue built from the register-level protocol.
module tb_uart_8250_ctrl;

  localparam logic [31:0] BASE  = 32'h1250_0000;
  localparam logic [31:0] A_RBR = BASE + 32'h00;
  localparam logic [31:0] A_IER = BASE + 32'h04;
  localparam logic [31:0] A_FCR = BASE + 32'h08;
  localparam logic [31:0] A_LCR = BASE + 32'h0C;
  localparam logic [31:0] A_LSR = BASE + 32'h14;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [7:0]  dat;
    int          tag;   // 1: last init write, 2: THR write
  } exp_t;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic [31:0] ADR_O, DAT_O, DAT_I;
  logic        WE_O, STB_O, ACK_I, CYC_O, INT_I;
  logic [3:0]  SEL_O;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, init_done, bus_err;

  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        exp_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  rx_fifo[$];
  int          fifo_cnt = 0;
  logic        spur = 1'b0;
  int          busy = 0;
  logic        hold_ack = 1'b0;

  uart_8250_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .ADR_O(ADR_O), .DAT_O(DAT_O), .DAT_I(DAT_I),
    .WE_O(WE_O), .SEL_O(SEL_O), .STB_O(STB_O), .ACK_I(ACK_I), .CYC_O(CYC_O),
    .INT_I(INT_I), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .init_done(init_done), .bus_err(bus_err)
  );

  always #5 CLK_I = ~CLK_I;

  always_comb INT_I = (fifo_cnt != 0) || spur;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void expect_acc(input logic we, input logic [31:0] adr,
                                     input logic [7:0] dat, input int tag);
    exp_t e;
    e.we = we; e.adr = adr; e.dat = dat; e.tag = tag;
    exp_q.push_back(e);
  endfunction

  function automatic void expect_init();
    expect_acc(1'b1, A_LCR, 8'h83, 0);
    expect_acc(1'b1, A_RBR, 8'h1B, 0);
    expect_acc(1'b1, A_IER, 8'h00, 0);
    expect_acc(1'b1, A_LCR, 8'h03, 0);
    expect_acc(1'b1, A_FCR, 8'h07, 0);
    expect_acc(1'b1, A_IER, 8'h01, 1);
  endfunction

  // UART register model: LSR.DR follows the FIFO, LSR.THRE is withheld for 'busy' polls
  function automatic logic [31:0] respond();
    logic [31:0] junk;
    logic [7:0]  b;
    junk = $urandom;
    b    = 8'h00;
    if (!WE_O) begin
      if (ADR_O == A_LSR) begin
        b = ((busy > 0) ? 8'h00 : 8'h60) | ((fifo_cnt != 0) ? 8'h01 : 8'h00);
        if (busy > 0) busy--;
        spur = 1'b0;
      end else if (ADR_O == A_RBR && rx_fifo.size() != 0) begin
        b = rx_fifo.pop_front();
        fifo_cnt--;
      end
    end
    return {junk[31:8], b};
  endfunction

  initial begin : slave
    int wcnt, lat;
    ACK_I = 1'b0; DAT_I = '0; wcnt = 0; lat = 0;
    forever begin
      @(posedge CLK_I); #1;
      if (ACK_I || RST_I) begin
        ACK_I = 1'b0; wcnt = 0; lat = $urandom_range(0, 2);
      end else if (STB_O && !hold_ack) begin
        if (wcnt >= lat) begin ACK_I = 1'b1; DAT_I = respond(); wcnt = 0; end
        else wcnt++;
      end else if (!STB_O) wcnt = 0;
    end
  end

  initial begin : bus_mon
    exp_t e;
    forever begin
      @(negedge CLK_I);
      if (STB_O && ACK_I) begin
        check("txn_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("adr", ADR_O, e.adr);
          check("we", WE_O, e.we);
          check("sel", SEL_O, 4'b0001);
          check("cyc", CYC_O, 1);
          if (e.we) check("wdat", DAT_O, {24'h0, e.dat});
          if (e.tag == 1) begin
            check("init_done_pre", init_done, 0);
            @(negedge CLK_I);
            check("init_done", init_done, 1);
          end else if (e.tag == 2) begin
            @(negedge CLK_I);
            check("tx_ready_rise", tx_ready, 1);
          end
        end
      end
    end
  end

  initial begin : rx_mon
    logic [7:0] eb;
    forever begin
      @(negedge CLK_I);
      if (rx_valid) begin
        check("rx_pending", rx_q.size() != 0, 1);
        if (rx_q.size() != 0) begin
          eb = rx_q.pop_front();
          check("rx_data", rx_data, eb);
        end
        @(negedge CLK_I);
        check("rx_pulse", rx_valid, 0);
      end
    end
  end

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || rx_q.size() != 0) && n < 2000) begin
      @(negedge CLK_I); n++;
    end
    check("drain", (exp_q.size() == 0 && rx_q.size() == 0), 1);
    repeat (4) @(negedge CLK_I);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!tx_ready && n < 500) begin @(negedge CLK_I); n++; end
    check("tx_ready_wait", tx_ready, 1);
    tx_data = b; tx_valid = 1'b1;
    @(posedge CLK_I); #1 tx_valid = 1'b0;
    @(negedge CLK_I);
    check("tx_ready_fall", tx_ready, 0);
  endtask

  task automatic wait_stb();
    int n = 0;
    while (!STB_O && n < 100) begin @(negedge CLK_I); n++; end
    check("stb_rise", STB_O, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int kind, k, n;
    logic [7:0] b, rb;
    RST_I = 1'b1; tx_valid = 1'b0; tx_data = '0;
    repeat (3) @(negedge CLK_I);
    check("rst_cyc", CYC_O, 0);
    check("rst_stb", STB_O, 0);
    check("rst_we", WE_O, 0);
    check("rst_adr", ADR_O, 0);
    check("rst_dat", DAT_O, 0);
    check("rst_sel", SEL_O, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_init_done", init_done, 0);
    check("rst_bus_err", bus_err, 0);

    expect_init();
    RST_I = 1'b0;
    wait_drain();
    check("init_tx_ready", tx_ready, 1);

    for (int it = 0; it < 24; it++) begin
      kind = $urandom_range(0, 3);
      b    = 8'($urandom);
      n    = $urandom_range(1, 3);
      case (kind)
        0: begin
          k = $urandom_range(0, 3);
          busy = k;
          for (int j = 0; j <= k; j++) expect_acc(1'b0, A_LSR, 8'h00, 0);
          expect_acc(1'b1, A_RBR, b, 2);
          send_byte(b);
        end
        1: begin
          for (int j = 0; j < n; j++) begin
            rb = 8'($urandom);
            rx_fifo.push_back(rb); rx_q.push_back(rb);
            expect_acc(1'b0, A_LSR, 8'h00, 0);
            expect_acc(1'b0, A_RBR, 8'h00, 0);
          end
          fifo_cnt = n;
        end
        2: begin
          check("combo_tx_ready", tx_ready, 1);
          for (int j = 0; j < n; j++) begin
            rb = 8'($urandom);
            rx_fifo.push_back(rb); rx_q.push_back(rb);
            expect_acc(1'b0, A_LSR, 8'h00, 0);
            expect_acc(1'b0, A_RBR, 8'h00, 0);
          end
          expect_acc(1'b0, A_LSR, 8'h00, 0);
          expect_acc(1'b1, A_RBR, b, 2);
          tx_data = b; tx_valid = 1'b1; fifo_cnt = n;
          @(posedge CLK_I); #1 tx_valid = 1'b0;
          @(negedge CLK_I);
          check("combo_tx_ready_fall", tx_ready, 0);
        end
        default: begin
          expect_acc(1'b0, A_LSR, 8'h00, 0);
          spur = 1'b1;
        end
      endcase
      wait_drain();
    end

`ifdef UART_CTRL_TIMEOUT_EN
    hold_ack = 1'b1;
    b = 8'($urandom);
    send_byte(b);
    wait_stb();
    n = 0;
    while (STB_O && n < 100) begin n++; @(negedge CLK_I); end
    check("timeout_len", n, 8);
    check("bus_err_set", bus_err, 1);
    expect_acc(1'b0, A_LSR, 8'h00, 0);
    expect_acc(1'b1, A_RBR, b, 2);
    hold_ack = 1'b0;
    wait_drain();
    check("bus_err_sticky", bus_err, 1);
`endif

    hold_ack = 1'b1;
    send_byte(8'($urandom));
    wait_stb();
    RST_I = 1'b1;
    @(negedge CLK_I);
    check("rst_mid_stb", STB_O, 0);
    check("rst_mid_cyc", CYC_O, 0);
    check("rst_mid_adr", ADR_O, 0);
    check("rst_mid_init_done", init_done, 0);
    check("rst_mid_bus_err", bus_err, 0);
    hold_ack = 1'b0;
    busy = 0;
    expect_init();
    RST_I = 1'b0;
    wait_drain();
    repeat (20) @(negedge CLK_I);
    check("post_rst_tx_ready", tx_ready, 1);
    check("post_rst_stb", STB_O, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
